// File: rtl/piece_queue.sv
// Next-piece preview queue: requests pieces from the generator, holds DEPTH of them
// and dequeues on pop. Define PIECE_QUEUE_BAG7_EN to enable the 7-bag duplicate filter.
module piece_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 block_type,
    input  logic                       pop,
    output logic                       gen_enable,
    output logic                       piece_valid,
    output logic [2:0]                 next_piece,
    output logic [3*DEPTH-1:0]         preview,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                pieces_dealt
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0] EMPTY_SLOT = 3'd7;

    logic [2:0]    slot_q [DEPTH];
    logic [2:0]    slot_d [DEPTH];
    logic [2:0]    shift_src [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          valid_q;
    logic          valid_d;
    logic [15:0]   dealt_q;
    logic [15:0]   dealt_d;

    logic          pop_acc;
    logic          push_acc;
    logic          reject;
    logic [CW-1:0] fill_idx;

    // Refill is allowed on a full queue only when the head leaves on the same edge.
    always_comb begin
        pop_acc    = pop && valid_q;
        gen_enable = !rst && ((count_q < DEPTH_C) || pop_acc);
    end

`ifdef PIECE_QUEUE_BAG7_EN
    logic [6:0] mask_q;
    logic [6:0] mask_d;
    logic [7:0] mask_ext;
    logic [7:0] hit_onehot;
    logic [6:0] mask_set;

    always_comb begin
        mask_ext   = {1'b0, mask_q};
        hit_onehot = 8'b1 << block_type;
        mask_set   = mask_q | hit_onehot[6:0];
        reject     = gen_enable && mask_ext[block_type];
        mask_d     = mask_q;
        if (push_acc) begin
            // A completed bag starts a fresh one instead of saturating.
            mask_d = (mask_set == 7'h7F) ? 7'h00 : mask_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 7'h00;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    always_comb begin
        reject = 1'b0;
    end
`endif

    always_comb begin
        push_acc = gen_enable && !reject;
        fill_idx = pop_acc ? (count_q - CW'(1)) : count_q;
        count_d  = count_q - CW'(pop_acc) + CW'(push_acc);
        valid_d  = (count_d != '0);
        dealt_d  = dealt_q + 16'(pop_acc);
    end

    // Per-slot next state: shift toward the head on pop, then drop the new piece
    // into the first free slot left after the shift.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        if (gi < DEPTH - 1) begin : g_mid
            assign shift_src[gi] = slot_q[gi+1];
        end else begin : g_tail
            assign shift_src[gi] = EMPTY_SLOT;
        end

        always_comb begin
            slot_d[gi] = pop_acc ? shift_src[gi] : slot_q[gi];
            if (push_acc && (fill_idx == CW'(gi))) begin
                slot_d[gi] = block_type;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                slot_q[gi] <= EMPTY_SLOT;
            end else begin
                slot_q[gi] <= slot_d[gi];
            end
        end

        assign preview[3*gi +: 3] = slot_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            valid_q <= 1'b0;
            dealt_q <= 16'h0000;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            dealt_q <= dealt_d;
        end
    end

    assign next_piece   = slot_q[0];
    assign piece_valid  = valid_q;
    assign count        = count_q;
    assign pieces_dealt = dealt_q;

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: directed fill/pop/reset/bag scenarios, then
// randomized traffic against a queue-based reference model.
module tb_piece_queue;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       block_type = 3'd0;
    logic             pop = 1'b0;
    logic             gen_enable;
    logic             piece_valid;
    logic [2:0]       next_piece;
    logic [3*DEPTH-1:0] preview;
    logic [CW-1:0]    count;
    logic [15:0]      pieces_dealt;

    piece_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .block_type   (block_type),
        .pop          (pop),
        .gen_enable   (gen_enable),
        .piece_valid  (piece_valid),
        .next_piece   (next_piece),
        .preview      (preview),
        .count        (count),
        .pieces_dealt (pieces_dealt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int step_no = 0;

    // Reference model state
    int q[$];
    int m_dealt = 0;
    int m_mask = 0;
    bit bag_on;
    bit last_ge;

    // Generator emulation: raw samples, advancing whenever the request is high
    int seq[16] = '{1, 3, 0, 0, 6, 2, 5, 4, 1, 3, 6, 0, 2, 4, 5, 1};
    int seq_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    function automatic logic [3*DEPTH-1:0] exp_preview();
        logic [3*DEPTH-1:0] e;
        for (int k = 0; k < DEPTH; k++) begin
            e[3*k +: 3] = (k < q.size()) ? 3'(q[k]) : 3'd7;
        end
        return e;
    endfunction

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("piece_valid", 32'(piece_valid), 32'(q.size() != 0));
        chk("next_piece", 32'(next_piece), (q.size() != 0) ? 32'(q[0]) : 32'd7);
        chk("preview", 32'(preview), 32'(exp_preview()));
        chk("pieces_dealt", 32'(pieces_dealt), 32'(m_dealt & 16'hFFFF));
    endtask

    // One clock of stimulus: drive, check the request path, clock, update model, check.
    task automatic step(input logic r, input logic p, input logic [2:0] b);
        bit pop_acc;
        bit ge;
        bit rej;
        rst = r;
        pop = p;
        block_type = b;
        pop_acc = p && (q.size() > 0);
        ge = !r && ((q.size() < DEPTH) || pop_acc);
        rej = bag_on && ge && ((m_mask >> b) & 1);
        #1;
        chk("gen_enable", 32'(gen_enable), 32'(ge));
        last_ge = ge;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_dealt = 0;
            m_mask = 0;
        end else begin
            if (pop_acc) begin
                void'(q.pop_front());
                m_dealt++;
            end
            if (ge && !rej) begin
                q.push_back(int'(b));
                if (bag_on) begin
                    m_mask = m_mask | (1 << b);
                    if (m_mask == 127) m_mask = 0;
                end
            end
        end
        #1;
        check_state();
        step_no++;
        $display("step %0d rst=%0b pop=%0b bt=%0d ge=%0b cnt=%0d next=%0d dealt=%0d",
                 step_no, r, p, b, ge, count, next_piece, pieces_dealt);
        @(negedge clk);
    endtask

    task automatic gen_step(input logic r, input logic p);
        step(r, p, 3'(seq[seq_idx]));
        if (last_ge) seq_idx = (seq_idx + 1) % 16;
    endtask

    initial begin
`ifdef PIECE_QUEUE_BAG7_EN
        bag_on = 1'b1;
`else
        bag_on = 1'b0;
`endif
        @(negedge clk);

        // Reset with pop held high; queue stays empty, nothing is dealt
        gen_step(1'b1, 1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_preview", 32'(preview), 32'hFFF);
        chk("rst_next", 32'(next_piece), 32'd7);

        // First post-reset cycle still popping: ignored, no underflow
        gen_step(1'b0, 1'b1);
        chk("empty_pop_count", 32'(count), 32'd1);
        chk("empty_pop_dealt", 32'(pieces_dealt), 32'd0);

        // Fill with pop low
        for (int i = 0; i < 4; i++) gen_step(1'b0, 1'b0);
`ifdef PIECE_QUEUE_BAG7_EN
        chk("fill_preview_bag", 32'(preview), 32'hC19);
`else
        chk("fill_preview", 32'(preview), 32'h019);
`endif
        chk("fill_full", 32'(count), 32'd4);

        // Single pop on a full queue refills the tail on the same edge
        gen_step(1'b0, 1'b1);
        chk("pop_next", 32'(next_piece), 32'd3);
        chk("pop_count", 32'(count), 32'd4);
        chk("pop_dealt", 32'(pieces_dealt), 32'd1);
`ifdef PIECE_QUEUE_BAG7_EN
        chk("pop_slot3", 32'(preview[11:9]), 32'd2);
`else
        chk("pop_slot3", 32'(preview[11:9]), 32'd6);
`endif
        gen_step(1'b0, 1'b0);

        // Mid-operation reset while three pieces are queued and one was dealt
        gen_step(1'b1, 1'b0);
        gen_step(1'b0, 1'b0);
        gen_step(1'b0, 1'b1);
        gen_step(1'b0, 1'b0);
        gen_step(1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_dealt", 32'(pieces_dealt), 32'd1);
        gen_step(1'b1, 1'b1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_preview", 32'(preview), 32'hFFF);
        chk("mid_rst_dealt", 32'(pieces_dealt), 32'd0);

        // Bag wrap: pieces 0..6 then 0 again, popping every cycle
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i % 7));
        chk("wrap_next", 32'(next_piece), 32'd0);
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_dealt", 32'(pieces_dealt), 32'd7);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4),
                 3'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piece_queue.md
# piece_queue

Next-piece preview queue that sits directly downstream of the `counter` piece generator. It drives the generator's `enable` and captures `block_type` into a DEPTH-entry FIFO. It presents the head piece and a packed preview bus to the game controller, and dequeues on a pop handshake. An optional 7-bag filter rejects duplicate pieces within a bag.

## Interface
- `DEPTH`, default 4: number of queued or preview slots; legal range 2..8.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `block_type` input 3: current piece from `counter`; values 0..6 only.
- `gen_enable` output 1: drives `counter.enable`; the generator advances on the same edge the queue samples.
- `pop` input 1: controller consumes the head piece.
- `piece_valid` output 1: head slot holds a real piece.
- `next_piece` output 3: head piece; equals `preview[2:0]`.
- `preview` output 3*DEPTH: slot k is at `[3k+2:3k]`; slot 0 is the head; empty slots read 3'd7.
- `count` output $clog2(DEPTH+1): number of occupied slots.
- `pieces_dealt` output 16: accepted pops, wraps at 16'hFFFF to 0.

## Operation
- **Reset values:**
  - `count`=0
  - every `preview` slot=3'd7
  - `piece_valid`=0
  - `next_piece`=3'd7
  - `pieces_dealt`=0
  - bag mask=7'b0
- **Generator request:** `gen_enable` = !rst && (count<DEPTH || pop_acc).
  - This path is combinational from `pop`.
  - `gen_enable` is 0 while `rst` is high.
- **Accept rules:**
  - pop_acc = pop && piece_valid.
  - A pop while empty is ignored; `pieces_dealt` is unchanged.
  - push_acc = gen_enable && !reject, where reject is defined only with BAG7_EN.
- **FIFO behaviour:**
  - On pop_acc, slots shift toward the head by one.
  - On push_acc, `block_type` is written into the first free slot after any shift.
  - Simultaneous pop_acc and push_acc: `count` is unchanged, the head advances, and the new piece lands in slot `count-1`.
  - Full with no pop: no request and no push; the generator holds.
- **Derived outputs:**
  - `piece_valid` = (count!=0), registered consistently with `count`.
  - `pieces_dealt` increments on each pop_acc.
- **Reset mid-operation:** the queue, mask and counters clear on the next edge; pending pieces are discarded.

## Timing
- **Fill latency:**
  - One piece is sampled per cycle while `gen_enable` is high.
  - With no rejects, `piece_valid` rises 1 cycle after reset deasserts.
  - The queue is full DEPTH cycles after reset deasserts.
- **Pop:** pop_acc at edge N means `next_piece` shows the next piece after edge N, with zero bubble.
- **Refill:** the slot freed by a pop is refilled on that same edge when gen_enable && !reject.
- **Sampling alignment:** `block_type` is sampled in the cycle `gen_enable` is high. The generator's new value is visible from the following cycle, so every advance yields a distinct sample.

## Configuration
- **`PIECE_QUEUE_BAG7_EN` defined:**
  - A 7-bit bag mask records the pieces accepted in the current bag.
  - reject = gen_enable && mask[block_type]. A rejected sample still advances the generator (`gen_enable` stays high) but is not stored.
  - On push_acc the mask bit is set. If the resulting mask would equal 7'h7F, the mask clears to 0 instead, starting a new bag.
  - Every 7 consecutive accepted pieces are a permutation of 0..6.
- **`PIECE_QUEUE_BAG7_EN` undefined:**
  - reject is tied to 0 and there is no mask register.
  - Every sample is stored, and duplicates are allowed.

## Test plan
Tests 1–4 and 6 run with `counter` attached, seed 16'hACE1, DEPTH=4; its raw sample sequence is 1,3,0,0,6. Test 5 drives `block_type` directly from the bench.
1. **Fill, bag off:** release reset and hold `pop`=0. Required response:
   - `count` = 1,2,3,4 on cycles 1..4.
   - `preview` = {0,0,3,1}, slot3..slot0, i.e. 12'b000_000_011_001.
   - `gen_enable` goes low from cycle 4.
2. **Fill, bag on:** same stimulus. Required response:
   - The second 0 is rejected.
   - The queue is full on cycle 5 with slot0..3 = 1,3,0,6.
   - The mask is 7'b1001011.
3. **Simultaneous pop and push:** on a full queue, pulse `pop` for 1 cycle. Required response:
   - `next_piece` changes from 1 to 3.
   - `count` stays 4.
   - `pieces_dealt`=1.
   - The new piece lands in slot 3.
4. **Empty pop:** assert `pop` during the reset cycle and the first post-reset cycle. Required response: `pieces_dealt` stays 0 and there is no underflow (`count`=1 after cycle 1).
5. **Bag wrap (bench-driven `block_type`):** with bag on, force `block_type` to 0..6 and then 0 while popping continuously. Required response:
   - After the 7th accept the mask reads 0.
   - The following 0 is accepted.
6. **Mid-operation reset:** assert `rst` while `count`=3. Required response on the next edge:
   - `count`=0
   - `preview`=all 3'd7
   - `pieces_dealt`=0
   - `gen_enable`=0 while `rst` is high.
